nn_alu_seq: RTL and testbench
=============================

NN_ALU_SEQ -- requirements
Module: nn_alu_seq

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32: ALU operand/result width.
REQ-002 SHALL have parameter MP_BITWIDTH, default 8: weight element width.
REQ-003 SHALL have parameter WEIGHT_SIZE, default 4: weight matrix is WEIGHT_SIZE x WEIGHT_SIZE elements (16 bytes).
REQ-004 SHALL have ports, clock and reset first:
 clk_i  in  1  clock; single clock domain, all state on rising edge
 rst_i  in  1  reset, synchronous, active-low
 cmd_valid_i  in  1  command offered
 cmd_ready_o  out  1  command accepted when high with cmd_valid_i
 cmd_op_i  in  4  opcode: 0001-1011 ALU ops; 1100 FC_RELU; 1101 CONV_POOL
 cmd_a_i  in  32  operand A (data1)
 cmd_b_i  in  32  operand B (data2 / bias)
 wgt_we_i  in  1  weight byte write request
 wgt_addr_i  in  4  weight byte index 0-15
 wgt_data_i  in  8  weight byte
 wgt_clr_i  in  1  clear weight-valid mask
 wgt_ack_o  out  1  write/clear taken this cycle (combinational)
 alu_ctrl_o  out  4  to ALU ALUCtrl_i
 alu_data1_o  out  32  to ALU data1_i
 alu_data2_o  out  32  to ALU data2_i
 alu_weight_o  out  128  to ALU weight_matrix
 alu_result_i  in  32  from ALU data_o
 alu_zero_i  in  1  from ALU Zero_o
 rsp_valid_o  out  1  response valid
 rsp_ready_i  in  1  response consumed when high with rsp_valid_o
 rsp_data_o  out  32  result
 rsp_zero_o  out  1  captured alu_zero_i of final pass
 rsp_err_o  out  1  command rejected
 busy_o  out  1  state != IDLE

Function
REQ-005 SHALL implement FSM states IDLE, EXEC1, EXEC2, RESP.
REQ-006 cmd_ready_o SHALL equal (state==IDLE); accept = cmd_valid_i & cmd_ready_o.
REQ-007 On accept, opcode/operands SHALL be registered; next state EXEC1, or RESP directly if rejected (REQ-012/013).
REQ-008 EXEC1: alu_ctrl_o = opcode (FC_RELU -> 1001, CONV_POOL -> 1010), alu_data1_o = A, alu_data2_o = B; alu_result_i/alu_zero_i latched at cycle end; next EXEC2 for fused ops, else RESP.
REQ-009 EXEC2: alu_data1_o = EXEC1 result, alu_data2_o = 0, alu_ctrl_o = 0111 (FC_RELU) or 1000 (CONV_POOL); result latched; next RESP.
REQ-010 Outside EXEC1/EXEC2, alu_ctrl_o, alu_data1_o, alu_data2_o SHALL be 0.
REQ-011 Latency: accept at cycle T -> rsp_valid_o high at T+2 (single), T+3 (fused).
REQ-012 Opcodes 0000, 1110, 1111 SHALL be rejected: rsp_err_o=1, rsp_data_o=0, rsp_zero_o=0, no ALU pass, rsp_valid_o at T+1.
REQ-013 Opcodes 1001, 1010, 1100, 1101 with weight-valid mask != 16'hFFFF SHALL be rejected as REQ-012.
REQ-014 RESP: rsp_valid_o and response fields SHALL hold stable until rsp_ready_i; on handshake next state IDLE, rsp_valid_o low next cycle.
REQ-015 Weight byte k SHALL occupy alu_weight_o[127-8k -: 8]; alu_weight_o driven from weight registers in all states.
REQ-016 Weight writes/clears SHALL be taken in IDLE and RESP only; in EXEC1/EXEC2 wgt_ack_o=0 and request dropped (requester retries).
REQ-017 Taken write SHALL store byte and set mask bit k; taken clear zeroes mask, not data.
REQ-018 Simultaneous clear and write SHALL store the byte and leave mask = only bit k set.
REQ-019 Write and command accept in same IDLE cycle: write SHALL take effect before EXEC1 and be used by it; mask check SHALL use mask after that write.
REQ-020 Arithmetic is entirely in the ALU; block SHALL not modify result bits.

Reset
REQ-021 rst_i low at a clock edge SHALL force IDLE, all outputs 0 (cmd_ready_o 1 after release), weight data and mask 0, regardless of state; an in-flight command is discarded with no response.

Verification
REQ-022 Reset, op 0001 A=5 B=7 accepted at T -> rsp_valid_o at T+2, rsp_data_o=12, rsp_zero_o=0, rsp_err_o=0.
REQ-023 Op 0111 A=32'hFFFFFFF6 -> rsp_data_o=0; op 0010 A=B=9 -> rsp_data_o=0, rsp_zero_o=1.
REQ-024 After reset, op 1001 -> rsp_valid_o at T+1, rsp_err_o=1; write 16 bytes then op 1001 -> rsp_err_o=0, alu_ctrl_o=1001 during EXEC1.
REQ-025 Op 1100 with full weights -> alu_ctrl_o 1001 at T+1, 0111 at T+2, alu_data1_o at T+2 = T+1 result, rsp_valid_o at T+3.
REQ-026 rsp_ready_i held low 5 cycles -> rsp_valid_o and data stable, cmd_ready_o 0, weight write in RESP acked; write attempted in EXEC1 -> wgt_ack_o 0.
REQ-027 rst_i low during EXEC2 -> next cycle IDLE, rsp_valid_o 0, mask 0, no response emitted.

Source files
------------

// File: rtl/nn_alu_seq.sv
// -----------------------------------------------------------------------------
// nn_alu_seq
// Sequencer that feeds an external neural-network ALU. It accepts one command
// at a time, runs one ALU pass (plain ops) or two chained passes (fused
// FC_RELU / CONV_POOL), and returns the captured ALU result. It also owns the
// 16-byte weight matrix and a per-byte valid mask that gates the weight ops.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. A valid, once raised, holds its payload
// stable until that transfer.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-low reset
//   cmd_*               command channel (opcode, operand A, operand B)
//   wgt_*               weight byte write / mask clear, wgt_ack_o is
//                       combinational and only high in IDLE or RESP
//   alu_*               drive / capture of the external ALU
//   rsp_*               response channel (result, zero flag, reject flag)
//   busy_o              FSM is not idle
//   state_o             FSM state, for observation only
// -----------------------------------------------------------------------------
module nn_alu_seq #(
   parameter int BITWIDTH    = 32,
   parameter int MP_BITWIDTH = 8,
   parameter int WEIGHT_SIZE = 4,
   localparam int NW = WEIGHT_SIZE * WEIGHT_SIZE,
   localparam int WW = NW * MP_BITWIDTH,
   localparam int AW = $clog2(NW)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [3:0]             cmd_op_i,
   input  logic [BITWIDTH-1:0]    cmd_a_i,
   input  logic [BITWIDTH-1:0]    cmd_b_i,
   input  logic                   wgt_we_i,
   input  logic [AW-1:0]          wgt_addr_i,
   input  logic [MP_BITWIDTH-1:0] wgt_data_i,
   input  logic                   wgt_clr_i,
   output logic                   wgt_ack_o,
   output logic [3:0]             alu_ctrl_o,
   output logic [BITWIDTH-1:0]    alu_data1_o,
   output logic [BITWIDTH-1:0]    alu_data2_o,
   output logic [WW-1:0]          alu_weight_o,
   input  logic [BITWIDTH-1:0]    alu_result_i,
   input  logic                   alu_zero_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [BITWIDTH-1:0]    rsp_data_o,
   output logic                   rsp_zero_o,
   output logic                   rsp_err_o,
   output logic                   busy_o,
   output logic [1:0]             state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC1 = 2'd1,
      S_EXEC2 = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                 state;
   logic [MP_BITWIDTH-1:0] wgt_mem [NW];
   logic [NW-1:0]          wgt_mask;
   logic                   fused_q;
   logic [3:0]             pass2_ctrl_q;

   // weight port
   logic          wgt_window;
   logic          wr_take;
   logic          clr_take;
   logic [NW-1:0] wr_onehot;
   logic [NW-1:0] mask_next;

   // command decode
   logic       accept;
   logic [3:0] dec_ctrl;
   logic [3:0] dec_pass2;
   logic       dec_fused;
   logic       dec_illegal;
   logic       dec_needs_w;
   logic       reject;

   // Weight traffic is only served while no ALU pass is reading the matrix.
   assign wgt_window = ((state == S_IDLE) || (state == S_RESP)) && rst_i;
   assign wr_take    = wgt_window && wgt_we_i;
   assign clr_take   = wgt_window && wgt_clr_i;
   assign wgt_ack_o  = wr_take || clr_take;
   assign wr_onehot  = {{(NW-1){1'b0}}, 1'b1} << wgt_addr_i;

   // Clear is applied first so clear+write leaves only the written bit set.
   always_comb begin
      mask_next = wgt_mask;
      if (clr_take) mask_next = '0;
      if (wr_take)  mask_next = mask_next | wr_onehot;
   end

   assign cmd_ready_o = (state == S_IDLE) && rst_i;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign busy_o      = (state != S_IDLE);
   assign state_o     = state;

   always_comb begin
      dec_ctrl    = cmd_op_i;
      dec_pass2   = 4'b0000;
      dec_fused   = 1'b0;
      dec_illegal = 1'b0;
      dec_needs_w = 1'b0;
      case (cmd_op_i)
         4'b0000, 4'b1110, 4'b1111: dec_illegal = 1'b1;
         4'b1001, 4'b1010:          dec_needs_w = 1'b1;
         4'b1100: begin                // FC_RELU: FC pass then RELU pass
            dec_ctrl    = 4'b1001;
            dec_pass2   = 4'b0111;
            dec_fused   = 1'b1;
            dec_needs_w = 1'b1;
         end
         4'b1101: begin                // CONV_POOL: CONV pass then POOL pass
            dec_ctrl    = 4'b1010;
            dec_pass2   = 4'b1000;
            dec_fused   = 1'b1;
            dec_needs_w = 1'b1;
         end
         default: ;
      endcase
   end

   // The mask check sees a weight write landing in the same cycle.
   assign reject = dec_illegal || (dec_needs_w && !(&mask_next));

   // Byte k sits at the top end of the flat vector for k = 0.
   for (genvar k = 0; k < NW; k++) begin : g_wpack
      assign alu_weight_o[WW-1-MP_BITWIDTH*k -: MP_BITWIDTH] = wgt_mem[k];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= S_IDLE;
         wgt_mask     <= '0;
         fused_q      <= 1'b0;
         pass2_ctrl_q <= 4'b0000;
         alu_ctrl_o   <= 4'b0000;
         alu_data1_o  <= '0;
         alu_data2_o  <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_data_o   <= '0;
         rsp_zero_o   <= 1'b0;
         rsp_err_o    <= 1'b0;
         for (int k = 0; k < NW; k++) wgt_mem[k] <= '0;
      end else begin
         if (wr_take) wgt_mem[wgt_addr_i] <= wgt_data_i;
         wgt_mask <= mask_next;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (reject) begin
                     state       <= S_RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_data_o  <= '0;
                     rsp_zero_o  <= 1'b0;
                  end else begin
                     state        <= S_EXEC1;
                     alu_ctrl_o   <= dec_ctrl;
                     alu_data1_o  <= cmd_a_i;
                     alu_data2_o  <= cmd_b_i;
                     fused_q      <= dec_fused;
                     pass2_ctrl_q <= dec_pass2;
                  end
               end
            end

            S_EXEC1: begin
               if (fused_q) begin
                  // First-pass result feeds the second pass unchanged.
                  state       <= S_EXEC2;
                  alu_ctrl_o  <= pass2_ctrl_q;
                  alu_data1_o <= alu_result_i;
                  alu_data2_o <= '0;
               end else begin
                  state       <= S_RESP;
                  alu_ctrl_o  <= 4'b0000;
                  alu_data1_o <= '0;
                  alu_data2_o <= '0;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= alu_result_i;
                  rsp_zero_o  <= alu_zero_i;
                  rsp_err_o   <= 1'b0;
               end
            end

            S_EXEC2: begin
               state       <= S_RESP;
               alu_ctrl_o  <= 4'b0000;
               alu_data1_o <= '0;
               alu_data2_o <= '0;
               rsp_valid_o <= 1'b1;
               rsp_data_o  <= alu_result_i;
               rsp_zero_o  <= alu_zero_i;
               rsp_err_o   <= 1'b0;
            end

            S_RESP: begin
               if (rsp_ready_i) begin
                  state       <= S_IDLE;
                  rsp_valid_o <= 1'b0;
                  rsp_data_o  <= '0;
                  rsp_zero_o  <= 1'b0;
                  rsp_err_o   <= 1'b0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_nn_alu_seq
// Directed bench for nn_alu_seq. A behavioural ALU answers the DUT's ALU port;
// expected responses are predicted from the command, the bench's own copy of
// the weight bytes/mask and the same ALU behaviour, queued at drive time and
// popped when the response appears.
// -----------------------------------------------------------------------------
module tb_nn_alu_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_op;
   logic [31:0]  cmd_a;
   logic [31:0]  cmd_b;
   logic         wgt_we;
   logic [3:0]   wgt_addr;
   logic [7:0]   wgt_data;
   logic         wgt_clr;
   logic         wgt_ack;
   logic [3:0]   alu_ctrl;
   logic [31:0]  alu_d1;
   logic [31:0]  alu_d2;
   logic [127:0] alu_w;
   logic [31:0]  alu_result;
   logic         alu_zero;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_data;
   logic         rsp_zero;
   logic         rsp_err;
   logic         busy;
   logic [1:0]   state;

   int n_checks = 0;
   int n_fail   = 0;

   // bench copy of the weight store
   logic [127:0] w_m;
   logic [15:0]  mask_m;

   // {err, zero, data}
   logic [33:0] exp_q[$];

   nn_alu_seq dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_a_i     (cmd_a),
      .cmd_b_i     (cmd_b),
      .wgt_we_i    (wgt_we),
      .wgt_addr_i  (wgt_addr),
      .wgt_data_i  (wgt_data),
      .wgt_clr_i   (wgt_clr),
      .wgt_ack_o   (wgt_ack),
      .alu_ctrl_o  (alu_ctrl),
      .alu_data1_o (alu_d1),
      .alu_data2_o (alu_d2),
      .alu_weight_o(alu_w),
      .alu_result_i(alu_result),
      .alu_zero_i  (alu_zero),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_zero_o  (rsp_zero),
      .rsp_err_o   (rsp_err),
      .busy_o      (busy),
      .state_o     (state)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- ALU
   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] d1,
                                         input logic [31:0] d2, input logic [127:0] w);
      logic [31:0] s;
      s = '0;
      case (c)
         4'd1:  s = d1 + d2;
         4'd2:  s = d1 - d2;
         4'd3:  s = d1 & d2;
         4'd4:  s = d1 | d2;
         4'd5:  s = d1 ^ d2;
         4'd6:  s = d1 << d2[4:0];
         4'd7:  s = d1[31] ? 32'd0 : d1;              // relu
         4'd8:  s = {1'b0, d1[31:1]};                 // pool
         4'd9: begin                                  // fc, index-weighted
            s = d1 + d2;
            for (int k = 0; k < 16; k++)
               s = s + 32'(w[127-8*k -: 8]) * 32'(k + 1);
         end
         4'd10: s = (d1 ^ w[127:96]) + d2;            // conv
         4'd11: s = d1 * {24'd0, d2[7:0]};
         default: s = '0;
      endcase
      return s;
   endfunction

   assign alu_result = alu_f(alu_ctrl, alu_d1, alu_d2, alu_w);
   assign alu_zero   = (alu_result == 32'd0);

   // ---------------------------------------------------------------- model
   function automatic bit is_reject(input logic [3:0] op);
      bit illegal, needw;
      illegal = (op == 4'd0) || (op == 4'd14) || (op == 4'd15);
      needw   = (op == 4'd9) || (op == 4'd10) || (op == 4'd12) || (op == 4'd13);
      return illegal || (needw && (mask_m != 16'hFFFF));
   endfunction

   function automatic logic [33:0] exp_resp(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      if (is_reject(op)) return {1'b1, 1'b0, 32'd0};
      if (op == 4'd12)      r = alu_f(4'd7, alu_f(4'd9,  a, b, w_m), 32'd0, w_m);
      else if (op == 4'd13) r = alu_f(4'd8, alu_f(4'd10, a, b, w_m), 32'd0, w_m);
      else                  r = alu_f(op, a, b, w_m);
      return {1'b0, (r == 32'd0), r};
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
      if (is_reject(op)) return 1;
      if (op == 4'd12 || op == 4'd13) return 3;
      return 2;
   endfunction

   // ---------------------------------------------------------------- check
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic model_write(input bit clr, input bit we, input logic [3:0] addr,
                              input logic [7:0] data);
      if (clr) mask_m = '0;
      if (we) begin
         w_m[127-8*int'(addr) -: 8] = data;
         mask_m[addr] = 1'b1;
      end
   endtask

   // Weight write and/or clear issued while the DUT is idle.
   task automatic wgt_op(input bit we, input bit clr, input logic [3:0] addr,
                         input logic [7:0] data);
      @(negedge clk);
      wgt_we = we; wgt_clr = clr; wgt_addr = addr; wgt_data = data;
      #1;
      chk("wgt_ack_idle", wgt_ack, 1'b1);
      model_write(clr, we, addr, data);
      @(posedge clk);
      #1;
      wgt_we = 1'b0; wgt_clr = 1'b0;
   endtask

   // One command from IDLE through response handshake.
   //   wr       : weight write in the accept cycle
   //   hold     : cycles rsp_ready stays low once the response is up
   //   resp_wr  : weight write during the first held RESP cycle
   //   exec_wr  : weight write attempted in EXEC1 (must be refused)
   task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit wr, input logic [3:0] waddr, input logic [7:0] wdata,
                           input int hold, input bit resp_wr, input bit exec_wr);
      logic [33:0] e;
      logic [3:0]  ctrl1, ctrl2;
      logic [31:0] d1_1, d2_1, d1_2, fc1;
      int          lat;
      bit          got;
      bit          rej;
      ctrl1 = '0; ctrl2 = '0; d1_1 = '0; d2_1 = '0; d1_2 = '0;
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      if (wr) begin
         wgt_we = 1'b1; wgt_addr = waddr; wgt_data = wdata;
         #1;
         chk("wgt_ack_with_cmd", wgt_ack, 1'b1);
         model_write(1'b0, 1'b1, waddr, wdata);
      end
      rej = is_reject(op);
      lat = exp_lat(op);
      fc1 = (op == 4'd13) ? alu_f(4'd10, a, b, w_m) : alu_f(4'd9, a, b, w_m);
      exp_q.push_back(exp_resp(op, a, b));
      got = 1'b0;
      for (int i = 1; i <= 10 && !got; i++) begin
         @(negedge clk);
         if (i == 1) begin
            cmd_valid = 1'b0;
            wgt_we    = 1'b0;
            ctrl1 = alu_ctrl; d1_1 = alu_d1; d2_1 = alu_d2;
            if (exec_wr) begin
               wgt_we = 1'b1; wgt_addr = waddr; wgt_data = wdata;
               #1;
               chk("wgt_ack_exec1", wgt_ack, 1'b0);
            end
         end
         if (i == 2) begin
            wgt_we = 1'b0;
            ctrl2 = alu_ctrl; d1_2 = alu_d1;
         end
         if (rsp_valid) begin
            got = 1'b1;
            chk("rsp_latency", i, lat);
         end
      end
      wgt_we = 1'b0;
      if (!got) begin
         chk("rsp_timeout", rsp_valid, 1'b1);
         void'(exp_q.pop_front());
         return;
      end
      // ALU routing during the passes
      if (!rej) begin
         if (op == 4'd12 || op == 4'd13) begin
            chk("pass1_ctrl", ctrl1, (op == 4'd12) ? 4'b1001 : 4'b1010);
            chk("pass2_ctrl", ctrl2, (op == 4'd12) ? 4'b0111 : 4'b1000);
            chk("pass2_data1", d1_2, fc1);
         end else begin
            chk("pass1_ctrl", ctrl1, op);
         end
         chk("pass1_data1", d1_1, a);
         chk("pass1_data2", d2_1, b);
      end
      chk("resp_alu_ctrl_idle", alu_ctrl, 4'b0000);
      e = exp_q.pop_front();
      chk("rsp_data", rsp_data, e[31:0]);
      chk("rsp_zero", rsp_zero, e[32]);
      chk("rsp_err",  rsp_err,  e[33]);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         wgt_we = 1'b0;
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_data",  rsp_data,  e[31:0]);
         chk("hold_cmd_ready", cmd_ready, 1'b0);
         if (resp_wr && h == 0) begin
            wgt_we = 1'b1; wgt_addr = waddr; wgt_data = wdata;
            #1;
            chk("wgt_ack_resp", wgt_ack, 1'b1);
            model_write(1'b0, 1'b1, waddr, wdata);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      wgt_we    = 1'b0;
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", rsp_valid, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("weights", alu_w, w_m);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------------------------------------------------------- sequence
   initial begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      wgt_we = 1'b0; wgt_addr = '0; wgt_data = '0; wgt_clr = 1'b0; rsp_ready = 1'b0;
      w_m = '0; mask_m = '0;

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready_low", cmd_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_cmd_ready", cmd_ready, 1'b1);
      chk("rel_alu_ctrl", alu_ctrl, 4'b0000);
      chk("rel_alu_d1", alu_d1, 32'd0);
      chk("rel_weights", alu_w, 128'd0);
      chk("rel_rsp_err", rsp_err, 1'b0);
      chk("rel_rsp_data", rsp_data, 32'd0);
      chk("rel_state", state, 2'd0);

      // plain ALU ops
      send_cmd(4'd1, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd7, 32'hFFFF_FFF6, 32'd3, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd2, 32'd9, 32'd9, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd2, 32'd100, 32'd1, 0, 0, 0, 0, 0, 0);

      // weight ops without weights, illegal opcodes
      send_cmd(4'd9,  32'd1, 32'd2, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd12, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd0,  32'd1, 32'd2, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd14, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd15, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0);

      // fill 15 bytes, the 16th lands with the FC command itself
      for (int k = 0; k < 15; k++) wgt_op(1'b1, 1'b0, 4'(k), 8'($urandom_range(1, 255)));
      chk("weights_partial", alu_w, w_m);
      send_cmd(4'd9, 32'd1000, 32'd20, 1, 4'd15, 8'hA5, 0, 0, 0);

      // fused ops, relu both positive and clamped
      send_cmd(4'd12, 32'd50, 32'd6, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd12, 32'h8000_0000, 32'd0, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd13, 32'h1234_5678, 32'h0000_0101, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd10, 32'hDEAD_BEEF, 32'd7, 0, 0, 0, 0, 0, 0);

      // response back-pressure with a weight write taken in RESP
      send_cmd(4'd1, 32'h0000_1000, 32'h0000_0234, 0, 4'd2, 8'h3C, 5, 1, 0);
      // weight write attempted in EXEC1 is refused
      send_cmd(4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 4'd4, 8'h5A, 0, 0, 1);

      // randomised traffic with full weights
      for (int n = 0; n < 10; n++) begin
         rop = 4'($urandom_range(1, 13));
         ra  = $urandom;
         rb  = $urandom;
         send_cmd(rop, ra, rb, 0, 0, 0, $urandom_range(0, 2), 0, 0);
      end

      // clear+write leaves a single mask bit, data survives
      wgt_op(1'b1, 1'b1, 4'd3, 8'h77);
      chk("weights_after_clrwr", alu_w, w_m);
      send_cmd(4'd12, 32'd5, 32'd5, 0, 0, 0, 0, 0, 0);
      wgt_op(1'b0, 1'b1, 4'd0, 8'd0);
      send_cmd(4'd9, 32'd5, 32'd5, 0, 0, 0, 0, 0, 0);

      // refill, then reset in the middle of a fused command
      for (int k = 0; k < 16; k++) wgt_op(1'b1, 1'b0, 4'(k), 8'($urandom_range(0, 255)));
      send_cmd(4'd13, 32'd77, 32'd88, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'd12; cmd_a = 32'd3; cmd_b = 32'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("exec2_state", state, 2'd2);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rsp_valid", rsp_valid, 1'b0);
      chk("midrst_alu_ctrl", alu_ctrl, 4'b0000);
      chk("midrst_weights", alu_w, 128'd0);
      rst = 1'b1;
      w_m = '0; mask_m = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", rsp_valid, 1'b0);
      end
      send_cmd(4'd9, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0);
      send_cmd(4'd1, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1, 0, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
